scan_counter_ctrl_19: RTL and testbench
=======================================

SCAN_COUNTER_CTRL_19 -- requirements
Module: scan_counter_ctrl_19

Interface
REQ-001 Parameter PRESCALE, default 10, meaning enabled clocks per count step; legal range 1 to 65535.
REQ-002 Parameter SCAN_DIV, default 4, meaning clocks each digit is driven per scan phase; legal range 1 to 255.
REQ-003 Port CLK, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1 bit, meaning reset; synchronous, active-high.
REQ-005 Port PORT_EN, input, 1 bit, meaning count enable; gates the prescaler.
REQ-006 Port PORT_UP, input, 1 bit, meaning direction: 1 counts up, 0 counts down.
REQ-007 Port PORT_LOAD, input, 1 bit, meaning synchronous load strobe.
REQ-008 Port PORT_LOAD_VAL, input, 5 bits, meaning value to load.
REQ-009 Port PORT_BCD, output, 5 bits, meaning current count 0..19, binary, for the 0..19 display decoder input.
REQ-010 Port PORT_UNITS, output, 4 bits, meaning count mod 10.
REQ-011 Port PORT_TENS, output, 1 bit, meaning 1 when count >= 10.
REQ-012 Port PORT_DIGIT_SEL, output, 2 bits, meaning digit enable: 01 units, 10 tens, 00 blank.
REQ-013 Port PORT_WRAP, output, 1 bit, meaning one-clock pulse on a wrap event.

Function
REQ-014 All outputs are registered; PORT_BCD, PORT_UNITS and PORT_TENS update on the same edge as the count.
REQ-015 Prescaler: counts 0..PRESCALE-1 while PORT_EN=1; holds its value while PORT_EN=0; a tick occurs on the edge where it equals PRESCALE-1, when it returns to 0.
REQ-016 With PRESCALE=1, a tick occurs on every clock with PORT_EN=1.
REQ-017 Tick with PORT_UP=1: the count increments; 19 goes to 0 and PORT_WRAP=1 for one clock.
REQ-018 Tick with PORT_UP=0: the count decrements; 0 goes to 19 and PORT_WRAP=1 for one clock.
REQ-019 PORT_LOAD=1 loads PORT_LOAD_VAL into the count on the next edge, regardless of PORT_EN.
REQ-020 PORT_LOAD_VAL values above 19 are clamped to 19 on load.
REQ-021 A load clears the prescaler to 0.
REQ-022 A load and a tick in the same cycle: the load wins, no step is taken, and PORT_WRAP=0.
REQ-023 Scan FSM states: UNITS for SCAN_DIV clocks, then BLANK_A for 1 clock, then TENS for SCAN_DIV clocks, then BLANK_B for 1 clock, then back to UNITS.
REQ-024 PORT_DIGIT_SEL is 01 in UNITS, 10 in TENS, and 00 in BLANK_A and BLANK_B.
REQ-025 The scan FSM free-runs independently of PORT_EN, PORT_LOAD and the count.
REQ-026 A full scan period is 2*SCAN_DIV+2 clocks.
REQ-027 The count never leaves the range 0..19 under any input sequence.

Reset
REQ-028 While RST=1 at a rising edge, the following are cleared, overriding PORT_LOAD and the tick:
- count 0: PORT_BCD=0, PORT_UNITS=0, PORT_TENS=0
- prescaler 0
- PORT_WRAP=0
- scan FSM in UNITS with its phase counter at 0, PORT_DIGIT_SEL=01
REQ-029 RST asserted mid-scan or mid-prescale aborts the operation; the block resumes from the reset state on the first edge after RST=0.

Configuration
REQ-030 Macro SCAN_SATURATE_EN, when defined, makes the count saturate instead of wrapping:
- up at 19 holds 19
- down at 0 holds 0
- PORT_WRAP stays 0
REQ-031 Without SCAN_SATURATE_EN, the wrap behaviour of REQ-017 and REQ-018 applies.

Verification
REQ-032 Wrap test:
- stimulus: RST 1 clock; PRESCALE=10; PORT_EN=1, PORT_UP=1 for 200 clocks
- response: PORT_BCD steps 0,1,..,19 then 0, one step every 10 clocks; PORT_WRAP is high exactly 1 clock at 19->0
REQ-033 Load test:
- stimulus: PORT_LOAD=1 with PORT_LOAD_VAL=25, then 13
- response: PORT_BCD=19 after the first load; after the second, PORT_BCD=13, PORT_UNITS=3, PORT_TENS=1, and the prescaler is restarted
REQ-034 Down-count test:
- stimulus: count 0, PORT_UP=0, PRESCALE=1, PORT_EN=1 for 1 clock
- response: PORT_BCD=19, PORT_WRAP=1; with SCAN_SATURATE_EN, PORT_BCD=0, PORT_WRAP=0
REQ-035 Collision test:
- stimulus: PORT_LOAD=1 with PORT_LOAD_VAL=5 on the prescaler terminal cycle, count 19, up
- response: PORT_BCD=5, PORT_WRAP=0
REQ-036 Scan test:
- stimulus: SCAN_DIV=4, free run
- response: PORT_DIGIT_SEL repeats the sequence 01x4, 00, 10x4, 00; RST=1 mid-TENS gives 01 on the next edge
REQ-037 Hold test:
- stimulus: PORT_EN=0 for 50 clocks mid-prescale
- response: PORT_BCD is unchanged; the step comes after the remaining prescale clocks once PORT_EN=1

Source files
------------

// File: rtl/scan_counter_ctrl_19_if.sv
// Bus bundle for scan_counter_ctrl_19: count controls in, count and scan outputs back.
interface scan_counter_ctrl_19_if;
  logic       PORT_EN;
  logic       PORT_UP;
  logic       PORT_LOAD;
  logic [4:0] PORT_LOAD_VAL;
  logic [4:0] PORT_BCD;
  logic [3:0] PORT_UNITS;
  logic       PORT_TENS;
  logic [1:0] PORT_DIGIT_SEL;
  logic       PORT_WRAP;

  modport master (
    output PORT_EN, PORT_UP, PORT_LOAD, PORT_LOAD_VAL,
    input  PORT_BCD, PORT_UNITS, PORT_TENS, PORT_DIGIT_SEL, PORT_WRAP
  );

  modport slave (
    input  PORT_EN, PORT_UP, PORT_LOAD, PORT_LOAD_VAL,
    output PORT_BCD, PORT_UNITS, PORT_TENS, PORT_DIGIT_SEL, PORT_WRAP
  );
endinterface

// File: rtl/scan_counter_ctrl_19.sv
// 0..19 up/down counter with prescaler, load and a two-digit display scan FSM.
// Optional macro SCAN_SATURATE_EN: count saturates at 0/19 instead of wrapping.
//
// state   | meaning
// UNITS   | units digit driven for SCAN_DIV clocks
// BLANK_A | both digits off for 1 clock
// TENS    | tens digit driven for SCAN_DIV clocks
// BLANK_B | both digits off for 1 clock
module scan_counter_ctrl_19 #(
  parameter int PRESCALE = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  scan_counter_ctrl_19_if.slave bus
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  SD_LAST = 8'(SCAN_DIV - 1);
  localparam logic [4:0]  CNT_MAX = 5'd19;

  typedef enum logic [1:0] {S_UNITS, S_BLANK_A, S_TENS, S_BLANK_B} scan_state_t;

  logic [15:0] prescale_q, prescale_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  units_q, units_d;
  logic        tens_q, tens_d;
  logic        wrap_q, wrap_d;
  logic        tick;

  scan_state_t state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [1:0]  sel_q, sel_d;

  always_comb begin
    tick       = bus.PORT_EN && (prescale_q == PS_LAST);
    prescale_d = prescale_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    // A load takes priority over a coincident tick and restarts the prescaler.
    if (bus.PORT_LOAD) begin
      count_d    = (bus.PORT_LOAD_VAL > CNT_MAX) ? CNT_MAX : bus.PORT_LOAD_VAL;
      prescale_d = '0;
    end else begin
      if (bus.PORT_EN) prescale_d = tick ? '0 : prescale_q + 16'd1;
      if (tick) begin
        if (bus.PORT_UP) begin
          if (count_q == CNT_MAX) begin
`ifdef SCAN_SATURATE_EN
            count_d = count_q;
`else
            count_d = '0;
            wrap_d  = 1'b1;
`endif
          end else begin
            count_d = count_q + 5'd1;
          end
        end else begin
          if (count_q == 5'd0) begin
`ifdef SCAN_SATURATE_EN
            count_d = count_q;
`else
            count_d = CNT_MAX;
            wrap_d  = 1'b1;
`endif
          end else begin
            count_d = count_q - 5'd1;
          end
        end
      end
    end
    tens_d  = (count_d >= 5'd10);
    units_d = tens_d ? 4'(count_d - 5'd10) : count_d[3:0];
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_UNITS: begin
        if (phase_q == SD_LAST) begin
          state_d = S_BLANK_A;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_BLANK_A: begin
        state_d = S_TENS;
        phase_d = '0;
      end
      S_TENS: begin
        if (phase_q == SD_LAST) begin
          state_d = S_BLANK_B;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: begin
        state_d = S_UNITS;
        phase_d = '0;
      end
    endcase
    case (state_d)
      S_UNITS: sel_d = 2'b01;
      S_TENS:  sel_d = 2'b10;
      default: sel_d = 2'b00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_q <= '0;
      count_q    <= '0;
      units_q    <= '0;
      tens_q     <= 1'b0;
      wrap_q     <= 1'b0;
      state_q    <= S_UNITS;
      phase_q    <= '0;
      sel_q      <= 2'b01;
    end else begin
      prescale_q <= prescale_d;
      count_q    <= count_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      wrap_q     <= wrap_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.PORT_BCD       = count_q;
  assign bus.PORT_UNITS     = units_q;
  assign bus.PORT_TENS      = tens_q;
  assign bus.PORT_WRAP      = wrap_q;
  assign bus.PORT_DIGIT_SEL = sel_q;

endmodule

// File: tb/tb_scan_counter_ctrl_19.sv
// Bench for scan_counter_ctrl_19: two instances (PRESCALE 10 and 1) against a cycle model scoreboard.
module tb_scan_counter_ctrl_19;

  localparam int PS_A = 10;
  localparam int PS_B = 1;
  localparam int SD   = 4;

  logic       clk;
  logic       rst;
  logic       en, up, load;
  logic [4:0] lv;

  scan_counter_ctrl_19_if ifa ();
  scan_counter_ctrl_19_if ifb ();

  assign ifa.PORT_EN = en;
  assign ifa.PORT_UP = up;
  assign ifa.PORT_LOAD = load;
  assign ifa.PORT_LOAD_VAL = lv;
  assign ifb.PORT_EN = en;
  assign ifb.PORT_UP = up;
  assign ifb.PORT_LOAD = load;
  assign ifb.PORT_LOAD_VAL = lv;

  scan_counter_ctrl_19 #(.PRESCALE(PS_A), .SCAN_DIV(SD)) dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  scan_counter_ctrl_19 #(.PRESCALE(PS_B), .SCAN_DIV(SD)) dut_b (.CLK(clk), .RST(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs_a, obs_b;
  assign obs_a = {ifa.PORT_BCD, ifa.PORT_UNITS, ifa.PORT_TENS, ifa.PORT_WRAP, ifa.PORT_DIGIT_SEL};
  assign obs_b = {ifb.PORT_BCD, ifb.PORT_UNITS, ifb.PORT_TENS, ifb.PORT_WRAP, ifb.PORT_DIGIT_SEL};

  typedef struct {
    int          inst;
    logic [12:0] val;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int   m_cnt [2];
  int   m_ps  [2];
  int   m_pos [2];
  logic m_wrap[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int pmax);
    bit tick;
    if (rst) begin
      m_cnt[k] = 0; m_ps[k] = 0; m_pos[k] = 0; m_wrap[k] = 1'b0;
    end else begin
      tick = en && (m_ps[k] == pmax - 1);
      m_wrap[k] = 1'b0;
      if (load) begin
        m_cnt[k] = (int'(lv) > 19) ? 19 : int'(lv);
        m_ps[k]  = 0;
      end else begin
        if (en) m_ps[k] = tick ? 0 : m_ps[k] + 1;
        if (tick) begin
          if (up) begin
            if (m_cnt[k] == 19) begin
`ifndef SCAN_SATURATE_EN
              m_cnt[k] = 0; m_wrap[k] = 1'b1;
`endif
            end else m_cnt[k] = m_cnt[k] + 1;
          end else begin
            if (m_cnt[k] == 0) begin
`ifndef SCAN_SATURATE_EN
              m_cnt[k] = 19; m_wrap[k] = 1'b1;
`endif
            end else m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
      m_pos[k] = (m_pos[k] + 1) % (2 * SD + 2);
    end
  endtask

  function automatic logic [12:0] model_val(input int k);
    logic [1:0] sel;
    if (m_pos[k] < SD)              sel = 2'b01;
    else if (m_pos[k] == SD)        sel = 2'b00;
    else if (m_pos[k] < 2 * SD + 1) sel = 2'b10;
    else                            sel = 2'b00;
    return {5'(m_cnt[k]), 4'(m_cnt[k] % 10), (m_cnt[k] >= 10), m_wrap[k], sel};
  endfunction

  // One clock: model predicts, DUT clocks, scoreboard compares.
  task automatic cycle();
    sb_t e;
    model_step(0, PS_A);
    e.inst = 0; e.val = model_val(0); sb_q.push_back(e);
    model_step(1, PS_B);
    e.inst = 1; e.val = model_val(1); sb_q.push_back(e);
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.inst == 0 ? "sb_a" : "sb_b", 32'(e.inst == 0 ? obs_a : obs_b), 32'(e.val));
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [1:0] pat [10];
  int wrap_cnt;

  initial begin
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ps[k] = 0; m_pos[k] = 0; m_wrap[k] = 1'b0;
    end
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 5'd0;
    #2;
    cycle();
    check_eq("rst_bcd", 32'(ifa.PORT_BCD), 32'd0);
    check_eq("rst_sel", 32'(ifa.PORT_DIGIT_SEL), 32'd1);
    check_eq("rst_wrap", 32'(ifa.PORT_WRAP), 32'd0);
    rst = 1'b0;

    // wrap test
    en = 1'b1; up = 1'b1;
    wrap_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (ifa.PORT_WRAP === 1'b1) wrap_cnt++;
      if (i == 189) check_eq("wrap_at19", 32'(ifa.PORT_BCD), 32'd19);
    end
`ifdef SCAN_SATURATE_EN
    check_eq("wrap_pulses", 32'(wrap_cnt), 32'd0);
    check_eq("wrap_end_bcd", 32'(ifa.PORT_BCD), 32'd19);
`else
    check_eq("wrap_pulses", 32'(wrap_cnt), 32'd1);
    check_eq("wrap_end_bcd", 32'(ifa.PORT_BCD), 32'd0);
`endif

    // load test: clamp, then load with EN low, then prescaler restart
    load = 1'b1; lv = 5'd25; cycle();
    check_eq("load_clamp", 32'(ifa.PORT_BCD), 32'd19);
    en = 1'b0; lv = 5'd13; cycle();
    check_eq("load_bcd", 32'(ifa.PORT_BCD), 32'd13);
    check_eq("load_units", 32'(ifa.PORT_UNITS), 32'd3);
    check_eq("load_tens", 32'(ifa.PORT_TENS), 32'd1);
    load = 1'b0; en = 1'b1; cycles(9);
    check_eq("ps_restart_hold", 32'(ifa.PORT_BCD), 32'd13);
    cycle();
    check_eq("ps_restart_step", 32'(ifa.PORT_BCD), 32'd14);

    // down-count test on PRESCALE=1 instance
    en = 1'b0; load = 1'b1; lv = 5'd0; cycle();
    load = 1'b0; up = 1'b0; en = 1'b1; cycle();
`ifdef SCAN_SATURATE_EN
    check_eq("down_bcd", 32'(ifb.PORT_BCD), 32'd0);
    check_eq("down_wrap", 32'(ifb.PORT_WRAP), 32'd0);
`else
    check_eq("down_bcd", 32'(ifb.PORT_BCD), 32'd19);
    check_eq("down_wrap", 32'(ifb.PORT_WRAP), 32'd1);
`endif
    en = 1'b0; cycle();

    // collision: load on the terminal prescale cycle at count 19
    load = 1'b1; lv = 5'd19; cycle();
    load = 1'b0; en = 1'b1; up = 1'b1; cycles(9);
    check_eq("coll_pre", 32'(ifa.PORT_BCD), 32'd19);
    load = 1'b1; lv = 5'd5; cycle();
    check_eq("coll_bcd", 32'(ifa.PORT_BCD), 32'd5);
    check_eq("coll_wrap", 32'(ifa.PORT_WRAP), 32'd0);

    // hold: pause mid-prescale
    load = 1'b0; cycles(4);
    en = 1'b0; cycles(50);
    check_eq("hold_bcd", 32'(ifa.PORT_BCD), 32'd5);
    en = 1'b1; cycles(5);
    check_eq("hold_resume_pre", 32'(ifa.PORT_BCD), 32'd5);
    cycle();
    check_eq("hold_resume_step", 32'(ifa.PORT_BCD), 32'd6);

    // scan sequence and reset mid-TENS
    en = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_eq("scan_seq", 32'(ifa.PORT_DIGIT_SEL), 32'(pat[(i + 1) % 10]));
    end
    cycles(6);
    check_eq("scan_tens", 32'(ifa.PORT_DIGIT_SEL), 32'd2);
    rst = 1'b1; cycle();
    check_eq("scan_rst", 32'(ifa.PORT_DIGIT_SEL), 32'd1);
    rst = 1'b0; cycle();
    check_eq("scan_resume", 32'(ifa.PORT_DIGIT_SEL), 32'd1);

    // random stress
    for (int i = 0; i < 400; i++) begin
      en   = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0);
      lv   = 5'($urandom_range(0, 31));
      rst  = ($urandom_range(0, 99) == 0);
      cycle();
      check_eq("range_a", 32'(ifa.PORT_BCD <= 5'd19), 32'd1);
      check_eq("range_b", 32'(ifb.PORT_BCD <= 5'd19), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
